// File: rtl/multiaddr_fork_pkg.sv
// Shared types and helpers for the multicast request fork.
package multiaddr_fork_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FORK = 1'b1
  } state_e;

  // Width needed to count from 0 up to n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multiaddr_fork_if.sv
// Request side (decoded multicast request) and fork side (per-index channels) of the fork.
interface multiaddr_fork_if #(
  parameter int unsigned NoIndices    = 4,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned PayloadWidth = 32
);
  import multiaddr_fork_pkg::*;

  localparam int unsigned CntWidth = cnt_width(NoIndices);

  logic                                 slv_valid_i;
  logic                                 slv_ready_o;
  logic [NoIndices-1:0]                 slv_select_i;
  logic [NoIndices-1:0][AddrWidth-1:0]  slv_addr_i;
  logic [NoIndices-1:0][AddrWidth-1:0]  slv_mask_i;
  logic [PayloadWidth-1:0]              slv_payload_i;
  logic [NoIndices-1:0]                 mst_valid_o;
  logic [NoIndices-1:0]                 mst_ready_i;
  logic [NoIndices-1:0][AddrWidth-1:0]  mst_addr_o;
  logic [NoIndices-1:0][AddrWidth-1:0]  mst_mask_o;
  logic [PayloadWidth-1:0]              mst_payload_o;
  logic                                 dec_error_o;
  logic [CntWidth-1:0]                  pending_cnt_o;

  // Environment view: issues requests and drives channel readies.
  modport master (
    output slv_valid_i, slv_select_i, slv_addr_i, slv_mask_i, slv_payload_i, mst_ready_i,
    input  slv_ready_o, mst_valid_o, mst_addr_o, mst_mask_o, mst_payload_o,
           dec_error_o, pending_cnt_o
  );

  // Fork view.
  modport slave (
    input  slv_valid_i, slv_select_i, slv_addr_i, slv_mask_i, slv_payload_i, mst_ready_i,
    output slv_ready_o, mst_valid_o, mst_addr_o, mst_mask_o, mst_payload_o,
           dec_error_o, pending_cnt_o
  );
endinterface

// File: rtl/multiaddr_fork_popcount.sv
// Combinational population count of a bit vector.
module multiaddr_fork_popcount #(
  parameter int unsigned Width    = 4,
  parameter int unsigned CntWidth = 3
) (
  input  logic [Width-1:0]    data_i,
  output logic [CntWidth-1:0] cnt_c
);
  always_comb begin
    cnt_c = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      cnt_c = cnt_c + CntWidth'(data_i[i]);
    end
  end
endmodule

// File: rtl/multiaddr_fork.sv
// Forks one decoded multicast request into NoIndices valid/ready channels and holds it
// in a one-entry register until every selected channel has handshaken.
module multiaddr_fork
  import multiaddr_fork_pkg::*;
#(
  parameter int unsigned NoIndices    = 4,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned PayloadWidth = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  multiaddr_fork_if.slave bus
);
  localparam int unsigned CntWidth = cnt_width(NoIndices);

  typedef logic [NoIndices-1:0]                sel_t;
  typedef logic [NoIndices-1:0][AddrWidth-1:0] addr_vec_t;

  state_e                  state_q, state_d;
  sel_t                    pending_q, pending_d, pending_left;
  addr_vec_t               addr_q, addr_d, mask_q, mask_d;
  logic [PayloadWidth-1:0] payload_q, payload_d;
  logic                    dec_error_q, dec_error_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic                    slv_ready_c, accept, load;

  // Channels still outstanding after this cycle's handshakes.
  assign pending_left = pending_q & ~bus.mst_ready_i;
  assign accept       = bus.slv_valid_i & slv_ready_c;
  assign load         = accept & (|bus.slv_select_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_FORK;
      ST_FORK: if (~|pending_left) state_d = load ? ST_FORK : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Accept a new request only once the last outstanding channels complete.
  always_comb begin
    slv_ready_c = 1'b1;
    case (state_q)
      ST_FORK: slv_ready_c = ~|pending_left;
      default: slv_ready_c = 1'b1;
    endcase
  end

  // A zero-select request is dropped without touching the data registers.
  always_comb begin
    pending_d   = pending_left;
    addr_d      = addr_q;
    mask_d      = mask_q;
    payload_d   = payload_q;
    dec_error_d = accept & ~|bus.slv_select_i;
    if (accept) pending_d = bus.slv_select_i;
    if (load) begin
      addr_d    = bus.slv_addr_i;
      mask_d    = bus.slv_mask_i;
      payload_d = bus.slv_payload_i;
    end
  end

  multiaddr_fork_popcount #(
    .Width    (NoIndices),
    .CntWidth (CntWidth)
  ) i_popcount (
    .data_i (pending_d),
    .cnt_c  (cnt_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q   <= '0;
      addr_q      <= '0;
      mask_q      <= '0;
      payload_q   <= '0;
      dec_error_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      payload_q   <= payload_d;
      dec_error_q <= dec_error_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.slv_ready_o   = slv_ready_c;
  assign bus.mst_valid_o   = pending_q;
  assign bus.mst_addr_o    = addr_q;
  assign bus.mst_mask_o    = mask_q;
  assign bus.mst_payload_o = payload_q;
  assign bus.dec_error_o   = dec_error_q;
  assign bus.pending_cnt_o = cnt_q;

  a_slv_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.slv_valid_i && !slv_ready_c) |=> (bus.slv_valid_i && $stable(bus.slv_select_i) &&
      $stable(bus.slv_addr_i) && $stable(bus.slv_mask_i) && $stable(bus.slv_payload_i)));

  a_no_indices: assert property (@(posedge clk_i) NoIndices > 0);

endmodule

// File: tb/tb_multiaddr_fork.sv
// Directed and randomized-backpressure checks of multiaddr_fork with NoIndices=4.
module tb_multiaddr_fork;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  mask;
    logic [15:0] payload;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   sent        = 0;
  logic accepted;
  exp_t e;
  exp_t sb_q[4][$];

  multiaddr_fork_if #(.NoIndices(4), .AddrWidth(8), .PayloadWidth(16)) bus ();

  multiaddr_fork #(.NoIndices(4), .AddrWidth(8), .PayloadWidth(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sb_empty();
    for (int i = 0; i < 4; i++) if (sb_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    rst               = 1'b1;
    bus.slv_valid_i   = 1'b0;
    bus.slv_select_i  = '0;
    bus.slv_addr_i    = '0;
    bus.slv_mask_i    = '0;
    bus.slv_payload_i = '0;
    bus.mst_ready_i   = '0;
    tick();
    tick();

    // Reset state
    chk("rst_mst_valid", 32'(bus.mst_valid_o), 32'h0);
    chk("rst_cnt", 32'(bus.pending_cnt_o), 32'h0);
    chk("rst_dec_error", 32'(bus.dec_error_o), 32'h0);
    chk("rst_payload", 32'(bus.mst_payload_o), 32'h0);
    chk("rst_addr", 32'(bus.mst_addr_o), 32'h0);
    rst = 1'b0;
    #1 chk("rst_slv_ready", 32'(bus.slv_ready_o), 32'h1);

    // All readies high: single-cycle fork
    tick();
    bus.slv_select_i  = 4'b1011;
    bus.slv_addr_i    = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.slv_mask_i    = {8'hF0, 8'h0F, 8'hFF, 8'h00};
    bus.slv_payload_i = 16'hA001;
    bus.mst_ready_i   = 4'b1111;
    bus.slv_valid_i   = 1'b1;
    #1 chk("t1_slv_ready_idle", 32'(bus.slv_ready_o), 32'h1);
    tick();
    bus.slv_valid_i = 1'b0;
    chk("t1_mst_valid", 32'(bus.mst_valid_o), 32'hB);
    chk("t1_cnt", 32'(bus.pending_cnt_o), 32'h3);
    chk("t1_addr0", 32'(bus.mst_addr_o[0]), 32'h11);
    chk("t1_addr3", 32'(bus.mst_addr_o[3]), 32'h44);
    chk("t1_mask1", 32'(bus.mst_mask_o[1]), 32'hFF);
    chk("t1_payload", 32'(bus.mst_payload_o), 32'hA001);
    #1 chk("t1_slv_ready_fork", 32'(bus.slv_ready_o), 32'h1);
    tick();
    chk("t1_valid_done", 32'(bus.mst_valid_o), 32'h0);
    chk("t1_cnt_done", 32'(bus.pending_cnt_o), 32'h0);

    // Staggered completion: ready[1] at +1, ready[2] at +3
    bus.slv_select_i  = 4'b0110;
    bus.slv_addr_i    = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus.slv_payload_i = 16'hB002;
    bus.mst_ready_i   = 4'b0000;
    bus.slv_valid_i   = 1'b1;
    #1 chk("t2_slv_ready_idle", 32'(bus.slv_ready_o), 32'h1);
    tick();
    bus.slv_valid_i = 1'b0;
    chk("t2_valid_p1", 32'(bus.mst_valid_o), 32'h6);
    chk("t2_cnt_p1", 32'(bus.pending_cnt_o), 32'h2);
    chk("t2_addr2_p1", 32'(bus.mst_addr_o[2]), 32'hC2);
    bus.mst_ready_i = 4'b0010;
    #1 chk("t2_slv_ready_p1", 32'(bus.slv_ready_o), 32'h0);
    tick();
    chk("t2_valid_p2", 32'(bus.mst_valid_o), 32'h4);
    chk("t2_cnt_p2", 32'(bus.pending_cnt_o), 32'h1);
    chk("t2_addr2_p2", 32'(bus.mst_addr_o[2]), 32'hC2);
    bus.mst_ready_i = 4'b0000;
    #1 chk("t2_slv_ready_p2", 32'(bus.slv_ready_o), 32'h0);
    tick();
    chk("t2_cnt_p3", 32'(bus.pending_cnt_o), 32'h1);
    chk("t2_addr2_p3", 32'(bus.mst_addr_o[2]), 32'hC2);
    bus.mst_ready_i = 4'b0100;
    #1 chk("t2_slv_ready_p3", 32'(bus.slv_ready_o), 32'h1);
    tick();
    chk("t2_valid_p4", 32'(bus.mst_valid_o), 32'h0);
    chk("t2_cnt_p4", 32'(bus.pending_cnt_o), 32'h0);

    // Back-to-back A then B, no bubble
    bus.mst_ready_i   = 4'b1111;
    bus.slv_select_i  = 4'b0001;
    bus.slv_addr_i    = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.slv_payload_i = 16'hC00A;
    bus.slv_valid_i   = 1'b1;
    tick();
    chk("t3_a_valid", 32'(bus.mst_valid_o), 32'h1);
    chk("t3_a_addr0", 32'(bus.mst_addr_o[0]), 32'h10);
    chk("t3_a_payload", 32'(bus.mst_payload_o), 32'hC00A);
    bus.slv_select_i  = 4'b1000;
    bus.slv_addr_i    = {8'h23, 8'h22, 8'h21, 8'h20};
    bus.slv_payload_i = 16'hC00B;
    #1 chk("t3_b_slv_ready", 32'(bus.slv_ready_o), 32'h1);
    tick();
    bus.slv_valid_i = 1'b0;
    chk("t3_b_valid", 32'(bus.mst_valid_o), 32'h8);
    chk("t3_b_addr3", 32'(bus.mst_addr_o[3]), 32'h23);
    chk("t3_b_payload", 32'(bus.mst_payload_o), 32'hC00B);
    chk("t3_b_cnt", 32'(bus.pending_cnt_o), 32'h1);
    tick();
    chk("t3_idle_valid", 32'(bus.mst_valid_o), 32'h0);

    // Zero select from IDLE: dropped, one-cycle error pulse
    bus.slv_select_i  = 4'b0000;
    bus.slv_addr_i    = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    bus.slv_payload_i = 16'hDEAD;
    bus.slv_valid_i   = 1'b1;
    #1 chk("t4_slv_ready", 32'(bus.slv_ready_o), 32'h1);
    tick();
    bus.slv_valid_i = 1'b0;
    chk("t4_dec_error", 32'(bus.dec_error_o), 32'h1);
    chk("t4_valid", 32'(bus.mst_valid_o), 32'h0);
    chk("t4_payload_kept", 32'(bus.mst_payload_o), 32'hC00B);
    chk("t4_cnt", 32'(bus.pending_cnt_o), 32'h0);
    tick();
    chk("t4_dec_error_off", 32'(bus.dec_error_o), 32'h0);
    chk("t4_valid_off", 32'(bus.mst_valid_o), 32'h0);

    // Zero select back-to-back after a completing fork
    bus.slv_select_i  = 4'b0100;
    bus.slv_payload_i = 16'hE001;
    bus.slv_valid_i   = 1'b1;
    tick();
    chk("t4b_valid", 32'(bus.mst_valid_o), 32'h4);
    bus.slv_select_i  = 4'b0000;
    bus.slv_payload_i = 16'hE002;
    tick();
    bus.slv_valid_i = 1'b0;
    chk("t4b_dec_error", 32'(bus.dec_error_o), 32'h1);
    chk("t4b_valid_off", 32'(bus.mst_valid_o), 32'h0);
    chk("t4b_payload_kept", 32'(bus.mst_payload_o), 32'hE001);
    tick();
    chk("t4b_dec_error_off", 32'(bus.dec_error_o), 32'h0);

    // Reset while channels are outstanding
    bus.slv_select_i  = 4'b0101;
    bus.slv_addr_i    = {8'h5D, 8'h5C, 8'h5B, 8'h5A};
    bus.slv_payload_i = 16'hF005;
    bus.mst_ready_i   = 4'b0000;
    bus.slv_valid_i   = 1'b1;
    tick();
    bus.slv_valid_i = 1'b0;
    chk("t5_valid_pre", 32'(bus.mst_valid_o), 32'h5);
    chk("t5_cnt_pre", 32'(bus.pending_cnt_o), 32'h2);
    #2 rst = 1'b1;
    #1 chk("t5_valid_rst", 32'(bus.mst_valid_o), 32'h0);
    chk("t5_cnt_rst", 32'(bus.pending_cnt_o), 32'h0);
    #2 rst = 1'b0;
    tick();
    bus.slv_select_i  = 4'b0010;
    bus.slv_addr_i    = {8'h00, 8'h00, 8'h77, 8'h00};
    bus.slv_payload_i = 16'hF006;
    bus.mst_ready_i   = 4'b1111;
    bus.slv_valid_i   = 1'b1;
    tick();
    bus.slv_valid_i = 1'b0;
    chk("t5_post_valid", 32'(bus.mst_valid_o), 32'h2);
    chk("t5_post_addr1", 32'(bus.mst_addr_o[1]), 32'h77);
    chk("t5_post_payload", 32'(bus.mst_payload_o), 32'hF006);
    tick();
    chk("t5_post_done", 32'(bus.mst_valid_o), 32'h0);

    // Random backpressure with per-channel in-order scoreboard
    for (int cyc = 0; cyc < 20000 && !(sent == 1000 && sb_empty()); cyc++) begin
      if (!bus.slv_valid_i && sent < 1000 && $urandom_range(0, 3) != 0) begin
        bus.slv_select_i  = 4'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) begin
          bus.slv_addr_i[i] = 8'($urandom);
          bus.slv_mask_i[i] = 8'($urandom);
        end
        bus.slv_payload_i = 16'($urandom);
        bus.slv_valid_i   = 1'b1;
      end
      bus.mst_ready_i = 4'($urandom_range(0, 15));
      #1;
      for (int i = 0; i < 4; i++) begin
        if (bus.mst_valid_o[i] && bus.mst_ready_i[i]) begin
          if (sb_q[i].size() == 0) begin
            chk($sformatf("rand_extra%0d", i), 32'h1, 32'h0);
          end else begin
            e = sb_q[i].pop_front();
            chk($sformatf("rand_addr%0d", i), 32'(bus.mst_addr_o[i]), 32'(e.addr));
            chk($sformatf("rand_mask%0d", i), 32'(bus.mst_mask_o[i]), 32'(e.mask));
            chk($sformatf("rand_payload%0d", i), 32'(bus.mst_payload_o), 32'(e.payload));
          end
        end
      end
      accepted = bus.slv_valid_i & bus.slv_ready_o;
      if (accepted) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.slv_select_i[i]) begin
            e.addr    = bus.slv_addr_i[i];
            e.mask    = bus.slv_mask_i[i];
            e.payload = bus.slv_payload_i;
            sb_q[i].push_back(e);
          end
        end
        sent++;
      end
      tick();
      if (accepted) bus.slv_valid_i = 1'b0;
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rand_drain%0d", i), 32'(sb_q[i].size()), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
